swp_bus_seq: RTL and testbench

Data-bus side sequencer for the ARMv4 SWP/SWPB instructions. It accepts one swap request from the execute stage, performs a locked read followed by a locked write on the data memory bus, and returns the old memory value to the core. It is the memory-facing counterpart of the core's swap-hold logic: the core raises a swap request and stalls, and this block runs the bus transaction and signals completion.

---
 rtl/swp_pkg.sv | 33 +++
 rtl/swp_lane_align.sv | 27 ++
 rtl/swp_bus_seq.sv | 150 +++++++++++++++
 tb/tb_swp_bus_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/swp_pkg.sv
// Shared types and lane helpers for the SWP/SWPB bus sequencer.
//   swp_state_e  : sequencer states
//   BE_ALL       : full-word byte enable
//   swp_be       : write byte enables for a word or byte swap
//   swp_rd_align : read data alignment (word rotate, or byte zero-extend)
package swp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } swp_state_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic [3:0] swp_be(input logic is_byte, input logic [1:0] a);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << a;
    return is_byte ? one_hot : BE_ALL;
  endfunction

  // Rotating right by 8*a also moves the addressed byte down to [7:0].
  function automatic logic [31:0] swp_rd_align(input logic is_byte, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [63:0] dd;
    logic [31:0] rot;
    dd  = {d, d} >> {a, 3'b000};
    rot = dd[31:0];
    return is_byte ? {24'h0, rot[7:0]} : rot;
  endfunction

endpackage

// File: rtl/swp_lane_align.sv
// Combinational lane steering for a swap.
//   is_byte    in  : 1 = SWPB, 0 = SWP
//   lane       in  : addr[1:0]
//   bus_rdata  in  : raw word from the bus
//   core_wdata in  : store value from the core
//   be         out : write byte enables
//   wdata      out : bus write data (byte replicated for SWPB)
//   rdata      out : aligned read data for the core
module swp_lane_align
  import swp_pkg::*;
(
  input  logic        is_byte,
  input  logic [1:0]  lane,
  input  logic [31:0] bus_rdata,
  input  logic [31:0] core_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  always_comb begin
    be    = swp_be(is_byte, lane);
    wdata = is_byte ? {4{core_wdata[7:0]}} : core_wdata;
    rdata = swp_rd_align(is_byte, lane, bus_rdata);
  end

endmodule

// File: rtl/swp_bus_seq.sv
// SWP/SWPB data-bus sequencer: locked read then locked write, old value returned to the core.
//   clk, rst (sync, active-high)
//   i_swp_vld/byte/addr/wdata : swap request from execute (sampled in idle only)
//   o_swp_busy/done/err/rdata : stall, completion pulse, error, old memory value
//   o_bus_*                   : registered bus request (req, we, lock, addr, be, wdata)
//   i_bus_ack/err/rdata       : bus response
module swp_bus_seq
  import swp_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_swp_vld,
  input  logic          i_swp_byte,
  input  logic [AW-1:0] i_swp_addr,
  input  logic [DW-1:0] i_swp_wdata,
  output logic          o_swp_busy,
  output logic          o_swp_done,
  output logic          o_swp_err,
  output logic [DW-1:0] o_swp_rdata,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic          o_bus_lock,
  output logic [AW-1:0] o_bus_addr,
  output logic [3:0]    o_bus_be,
  output logic [DW-1:0] o_bus_wdata,
  input  logic          i_bus_ack,
  input  logic          i_bus_err,
  input  logic [DW-1:0] i_bus_rdata
);

  swp_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          byte_q, byte_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;

  swp_lane_align u_lane (
    .is_byte    (byte_q),
    .lane       (addr_q[1:0]),
    .bus_rdata  (i_bus_rdata),
    .core_wdata (wdata_q),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .rdata      (lane_rdata)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    byte_d      = byte_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    bus_wdata_d = bus_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (i_swp_vld) begin
          state_d = StRd;
          addr_d  = i_swp_addr;
          byte_d  = i_swp_byte;
          wdata_d = i_swp_wdata;
          err_d   = 1'b0;
        end
      end
      StRd: begin
        if (i_bus_ack) begin
          if (i_bus_err) begin
            state_d = StDone;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = StWr;
            rdata_d     = lane_rdata;
            bus_wdata_d = lane_wdata;
          end
        end
      end
      StWr: begin
        if (i_bus_ack) begin
          state_d = StDone;
          err_d   = i_bus_err;
          if (i_bus_err) rdata_d = '0;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Bus controls follow the next state so they are registered yet line up with it;
    // lock therefore has no gap across the RD->WR hand-over.
    req_d = (state_d == StRd) || (state_d == StWr);
    we_d  = (state_d == StWr);
    if (state_d == StRd)      be_d = BE_ALL;
    else if (state_d == StWr) be_d = lane_be;
    else                      be_d = 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      byte_q      <= 1'b0;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      bus_wdata_q <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      byte_q      <= byte_d;
      wdata_q     <= wdata_d;
      req_q       <= req_d;
      we_q        <= we_d;
      be_q        <= be_d;
      bus_wdata_q <= bus_wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_bus_req   = req_q;
  assign o_bus_we    = we_q;
  assign o_bus_lock  = req_q;
  assign o_bus_addr  = {addr_q[AW-1:2], 2'b00};
  assign o_bus_be    = be_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_swp_done  = (state_q == StDone);
  assign o_swp_err   = err_q;
  assign o_swp_rdata = rdata_q;
  // Combinational so the core stalls in the same cycle it raises the request.
  assign o_swp_busy  = (state_q == StRd) || (state_q == StWr) ||
                       ((state_q == StIdle) && i_swp_vld);

endmodule

// File: tb/tb_swp_bus_seq.sv
// Directed bench for swp_bus_seq with a one-word memory slave and programmable wait states.
module tb_swp_bus_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld, sbyte;
  logic [31:0] saddr, swdata;
  logic        busy, done, serr;
  logic [31:0] srdata;
  logic        req, we, lock;
  logic [31:0] baddr;
  logic [3:0]  be;
  logic [31:0] bwdata;
  logic        ack, berr;
  logic [31:0] brdata;

  logic [31:0] mem;
  int          rd_wait, wr_wait, cnt, wr_req_seen;
  logic        rd_err, wr_err;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  swp_bus_seq #(.AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_swp_vld   (vld),
    .i_swp_byte  (sbyte),
    .i_swp_addr  (saddr),
    .i_swp_wdata (swdata),
    .o_swp_busy  (busy),
    .o_swp_done  (done),
    .o_swp_err   (serr),
    .o_swp_rdata (srdata),
    .o_bus_req   (req),
    .o_bus_we    (we),
    .o_bus_lock  (lock),
    .o_bus_addr  (baddr),
    .o_bus_be    (be),
    .o_bus_wdata (bwdata),
    .i_bus_ack   (ack),
    .i_bus_err   (berr),
    .i_bus_rdata (brdata)
  );

  // Slave: responds on the falling edge so the DUT samples a settled ack.
  always @(negedge clk) begin
    ack = 1'b0;
    berr = 1'b0;
    if (req && we) wr_req_seen++;
    if (rst || !req) begin
      cnt = 0;
    end else if (cnt == (we ? wr_wait : rd_wait)) begin
      ack  = 1'b1;
      berr = we ? wr_err : rd_err;
      cnt  = 0;
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) mem[8*i +: 8] = bwdata[8*i +: 8];
      end else begin
        brdata = mem;
      end
    end else begin
      cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic b, input logic [31:0] a, input logic [31:0] d);
    vld = 1'b1; sbyte = b; saddr = a; swdata = d;
    #0;
    chk("busy_on_request", {31'h0, busy}, 32'h1);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sbyte = 1'b0; saddr = '0; swdata = '0;
    ack = 1'b0; berr = 1'b0; brdata = '0; mem = '0;
    rd_wait = 0; wr_wait = 0; rd_err = 1'b0; wr_err = 1'b0; cnt = 0; wr_req_seen = 0;
    step(); step();

    // Reset state
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_we", {31'h0, we}, 32'h0);
    chk("rst_lock", {31'h0, lock}, 32'h0);
    chk("rst_be", {28'h0, be}, 32'h0);
    chk("rst_addr", baddr, 32'h0);
    chk("rst_wdata", bwdata, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, serr}, 32'h0);
    chk("rst_rdata", srdata, 32'h0);
    chk("rst_busy_lo", {31'h0, busy}, 32'h0);
    vld = 1'b1; #1;
    chk("rst_busy_follows_vld", {31'h0, busy}, 32'h1);
    step();
    vld = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_after_rst_req", {31'h0, req}, 32'h0);

    // SWP zero-wait
    mem = 32'h11223344;
    start(1'b0, 32'h100, 32'hDEADBEEF);
    step(); vld = 1'b0;
    chk("swp_c1_req", {31'h0, req}, 32'h1);
    chk("swp_c1_we", {31'h0, we}, 32'h0);
    chk("swp_c1_lock", {31'h0, lock}, 32'h1);
    chk("swp_c1_be", {28'h0, be}, 32'hF);
    chk("swp_c1_addr", baddr, 32'h100);
    step();
    chk("swp_c2_req", {31'h0, req}, 32'h1);
    chk("swp_c2_we", {31'h0, we}, 32'h1);
    chk("swp_c2_lock", {31'h0, lock}, 32'h1);
    chk("swp_c2_be", {28'h0, be}, 32'hF);
    chk("swp_c2_wdata", bwdata, 32'hDEADBEEF);
    chk("swp_c2_done", {31'h0, done}, 32'h0);
    step();
    chk("swp_c3_done", {31'h0, done}, 32'h1);
    chk("swp_c3_err", {31'h0, serr}, 32'h0);
    chk("swp_c3_rdata", srdata, 32'h11223344);
    chk("swp_c3_req", {31'h0, req}, 32'h0);
    chk("swp_c3_lock", {31'h0, lock}, 32'h0);
    chk("swp_c3_busy", {31'h0, busy}, 32'h0);
    chk("swp_mem", mem, 32'hDEADBEEF);
    step();
    chk("swp_c4_done", {31'h0, done}, 32'h0);
    chk("swp_c4_rdata_hold", srdata, 32'h11223344);

    // SWPB lane 2
    mem = 32'h11223344;
    start(1'b1, 32'h102, 32'h000000A5);
    step(); vld = 1'b0;
    chk("swpb_c1_be", {28'h0, be}, 32'hF);
    chk("swpb_c1_addr", baddr, 32'h100);
    step();
    chk("swpb_c2_be", {28'h0, be}, 32'h4);
    chk("swpb_c2_wdata", bwdata, 32'hA5A5A5A5);
    step();
    chk("swpb_done", {31'h0, done}, 32'h1);
    chk("swpb_rdata", srdata, 32'h00000022);
    chk("swpb_mem", mem, 32'h11A53344);
    step();

    // Unaligned SWP
    mem = 32'h11223344;
    start(1'b0, 32'h101, 32'h0BADF00D);
    step(); vld = 1'b0;
    chk("unal_addr", baddr, 32'h100);
    step();
    chk("unal_be", {28'h0, be}, 32'hF);
    chk("unal_wdata", bwdata, 32'h0BADF00D);
    step();
    chk("unal_rdata", srdata, 32'h44112233);
    chk("unal_mem", mem, 32'h0BADF00D);
    step();

    // Wait states: 3 on RD, 2 on WR
    rd_wait = 3; wr_wait = 2;
    mem = 32'h55667788;
    start(1'b0, 32'h200, 32'h12345678);
    for (int c = 1; c <= 7; c++) begin
      step(); vld = 1'b0;
      chk($sformatf("wait_c%0d_busy", c), {31'h0, busy}, 32'h1);
      chk($sformatf("wait_c%0d_lock", c), {31'h0, lock}, 32'h1);
      chk($sformatf("wait_c%0d_req", c), {31'h0, req}, 32'h1);
      chk($sformatf("wait_c%0d_we", c), {31'h0, we}, (c >= 5) ? 32'h1 : 32'h0);
      chk($sformatf("wait_c%0d_addr", c), baddr, 32'h200);
      chk($sformatf("wait_c%0d_be", c), {28'h0, be}, 32'hF);
      chk($sformatf("wait_c%0d_done", c), {31'h0, done}, 32'h0);
    end
    step();
    chk("wait_c8_done", {31'h0, done}, 32'h1);
    chk("wait_c8_busy", {31'h0, busy}, 32'h0);
    chk("wait_rdata", srdata, 32'h55667788);
    chk("wait_mem", mem, 32'h12345678);
    step();
    rd_wait = 0; wr_wait = 0;

    // Read error
    rd_err = 1'b1;
    wr_req_seen = 0;
    mem = 32'hAAAA5555;
    start(1'b0, 32'h300, 32'h99999999);
    step(); vld = 1'b0;
    chk("rerr_c1_req", {31'h0, req}, 32'h1);
    step();
    chk("rerr_done", {31'h0, done}, 32'h1);
    chk("rerr_err", {31'h0, serr}, 32'h1);
    chk("rerr_rdata", srdata, 32'h0);
    chk("rerr_req", {31'h0, req}, 32'h0);
    chk("rerr_lock", {31'h0, lock}, 32'h0);
    step();
    chk("rerr_no_write", wr_req_seen, 32'h0);
    chk("rerr_mem", mem, 32'hAAAA5555);
    chk("rerr_done_gone", {31'h0, done}, 32'h0);
    rd_err = 1'b0;

    // Reset while WR waits
    wr_wait = 5;
    mem = 32'h01020304;
    start(1'b0, 32'h400, 32'hCAFEF00D);
    step(); vld = 1'b0;
    step();
    chk("rstwr_in_wr", {31'h0, we}, 32'h1);
    rst = 1'b1;
    step();
    chk("rstwr_req", {31'h0, req}, 32'h0);
    chk("rstwr_lock", {31'h0, lock}, 32'h0);
    chk("rstwr_done", {31'h0, done}, 32'h0);
    chk("rstwr_rdata", srdata, 32'h0);
    step();
    rst = 1'b0; wr_wait = 0;
    step();
    chk("rstwr_no_done", {31'h0, done}, 32'h0);
    chk("rstwr_mem", mem, 32'h01020304);
    start(1'b0, 32'h404, 32'h0F0F0F0F);
    step(); vld = 1'b0;
    chk("fresh_c1_addr", baddr, 32'h404);
    step();
    step();
    chk("fresh_done", {31'h0, done}, 32'h1);
    chk("fresh_err", {31'h0, serr}, 32'h0);
    chk("fresh_rdata", srdata, 32'h01020304);
    chk("fresh_mem", mem, 32'h0F0F0F0F);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
